// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for an RV32I-subset datapath: walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITE_BACK and parks in ERROR on faults.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [1:0]       aluop,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'b0000,
    S_FETCH      = 4'b0001,
    S_DECODE     = 4'b0010,
    S_EXECUTE    = 4'b0011,
    S_MEM        = 4'b0100,
    S_WRITE_BACK = 4'b0101,
    S_ERROR      = 4'b1111
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] EC_ILLEGAL = 2'b01;
  localparam logic [1:0] EC_TIMEOUT = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic legal_in;
  logic timeout_hit;
  logic instr_end;
  logic ir_write_c, pc_write_c, pc_write_cond_c, reg_write_c, mem_we_c;

  always_comb begin
    legal_in = 1'b0;
    case (opcode)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH: legal_in = 1'b1;
      default:                                     legal_in = 1'b0;
    endcase
  end

  // The cycle that would push the wait count to MEM_TIMEOUT is the last one;
  // a mem_ready on that same cycle still completes the access.
  assign timeout_hit = !mem_ready && (({1'b0, wait_q} + 9'd1) == 9'(MEM_TIMEOUT));

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    wait_d          = wait_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    code_d          = code_q;
    instr_end       = 1'b0;
    mem_req         = 1'b0;
    mem_we_c        = 1'b0;
    iord            = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    reg_write_c     = 1'b0;
    alu_src         = 1'b0;
    mem_to_reg      = 1'b0;
    aluop           = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
          wait_d     = 8'd0;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = EC_TIMEOUT;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        op_d = opcode;
        if (!legal_in) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = EC_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        case (op_q)
          OP_R: begin
            aluop   = ALU_RFN;
            state_d = S_WRITE_BACK;
          end
          OP_IALU: begin
            aluop   = ALU_IFN;
            alu_src = 1'b1;
            state_d = S_WRITE_BACK;
          end
          OP_LOAD, OP_STORE: begin
            aluop   = ALU_ADD;
            alu_src = 1'b1;
            state_d = S_MEM;
            wait_d  = 8'd0;
          end
          OP_BRANCH: begin
            aluop           = ALU_SUB;
            pc_write_cond_c = 1'b1;
            instr_end       = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we_c = (op_q == OP_STORE);
        if (mem_ready) begin
          wait_d = 8'd0;
          if (op_q == OP_LOAD) state_d = S_WRITE_BACK;
          else                 instr_end = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = EC_TIMEOUT;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WRITE_BACK: begin
        reg_write_c = 1'b1;
        mem_to_reg  = (op_q == OP_LOAD);
        instr_end   = 1'b1;
      end

      S_ERROR: ;

      default: state_d = S_IDLE;
    endcase

    // run is only looked at here and in IDLE, so dropping it never aborts
    if (instr_end) begin
      cnt_d   = cnt_q + CNT_W'(1);
      wait_d  = 8'd0;
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  // Strobes that change datapath or counter state are held off while reset
  // is asserted, since that cycle's work is being discarded.
  assign ir_write      = ir_write_c      & ~reset;
  assign pc_write      = pc_write_c      & ~reset;
  assign pc_write_cond = pc_write_cond_c & ~reset;
  assign reg_write     = reg_write_c     & ~reset;
  assign mem_we        = mem_we_c        & ~reset;
  assign retire        = instr_end       & ~reset;

  assign state       = state_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign instr_count = cnt_q;
  assign err         = err_q;
  assign err_code    = code_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 7'd0;
      wait_q  <= 8'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multicycle control unit sequencing the RV32I-subset datapath through FETCH/DECODE/EXECUTE/MEM/WRITE_BACK, one instruction at a time. Drives IR/PC write enables, the shared instruction/data memory request handshake, register-file write, ALU operand select and `aluop`. Detects illegal opcodes and memory timeouts, then parks in a sticky ERROR state. Sits between the instruction register (source of `opcode`) and the datapath muxes/enables.

Parameters:
MEM_TIMEOUT, 15, max consecutive wait cycles in FETCH or MEM before the timeout error (1..255).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  level; 1 = keep executing instructions, 0 = stop at the next instruction boundary.
opcode  in  7  instr[6:0] from IR; valid from DECODE onward.
mem_ready  in  1  memory completes the current access this cycle.
state  out  4  current state register.
busy  out  1  state not IDLE and not ERROR.
mem_req  out  1  memory access request.
mem_we  out  1  memory write (stores only).
iord  out  1  address mux: 0 = PC, 1 = ALUOut.
ir_write  out  1  load IR.
pc_write  out  1  PC <= PC+4.
pc_write_cond  out  1  PC <= branch target if ALU zero.
reg_write  out  1  register-file write.
alu_src  out  1  ALU B operand: 0 = rs2, 1 = immediate.
mem_to_reg  out  1  WB data: 0 = ALUOut, 1 = MDR.
aluop  out  2  00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct.
retire  out  1  one-cycle pulse at instruction completion.
instr_count  out  CNT_W  retired instructions, wraps.
err  out  1  sticky error flag.
err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- States: IDLE=0000, FETCH=0001, DECODE=0010, EXECUTE=0011, MEM=0100, WRITE_BACK=0101, ERROR=1111. Any other encoding goes to IDLE.
- Reset (sync): state=IDLE, instr_count=0, err=0, err_code=00, wait counter=0, op_q=0. All control outputs are 0 in IDLE.
- Outputs are combinational from state, op_q and mem_ready (ir_write/pc_write also use mem_ready). Any output not listed for a state is 0.
- op_q captures `opcode` on the clock edge leaving DECODE. DECODE classifies using the `opcode` input directly.
- Opcode classes:
  - R = 0110011
  - IALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - anything else is illegal.
- IDLE: go to FETCH when run=1.
- FETCH: mem_req=1, iord=0, aluop=00.
  - mem_ready=1: ir_write=1, pc_write=1 in the same cycle; next state DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: if illegal, go to ERROR with err_code=01, err=1. Otherwise go to EXECUTE.
- EXECUTE, by op_q:
  - R: aluop=10, alu_src=0, then WRITE_BACK.
  - IALU: aluop=11, alu_src=1, then WRITE_BACK.
  - LOAD/STORE: aluop=00, alu_src=1, then MEM.
  - BRANCH: aluop=01, alu_src=0, pc_write_cond=1; this is the end of the instruction.
- MEM: mem_req=1, iord=1, mem_we=(op_q==STORE). Stay until mem_ready=1.
  - LOAD: then WRITE_BACK.
  - STORE: end of instruction.
- WRITE_BACK: reg_write=1, mem_to_reg=(op_q==LOAD). End of instruction.
- End of instruction:
  - retire=1 for that cycle; instr_count increments on the same edge (wraps at 2^CNT_W-1 to 0).
  - Next state is FETCH if run=1, else IDLE. `run` is sampled only at IDLE and at instruction end; deasserting it mid-instruction never aborts.
- Cycle counts with zero-wait memory:
  - R/IALU: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
- Wait counter:
  - Cleared on entry to FETCH/MEM and on completion.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - When it would reach MEM_TIMEOUT with mem_ready still 0, go to ERROR with err_code=10.
  - A mem_ready=1 arriving on the boundary cycle wins: no error.
- ERROR: all controls 0, busy=0, err=1. Exit only via reset.
- Reset mid-instruction or mid-wait returns to IDLE next edge. No pulse on ir_write/pc_write/reg_write in that cycle.

Test Plan:
- R-type, run=1, mem_ready tied 1, opcode=0110011 → states 1,2,3,5; reg_write=1 only in WB with aluop=10 in EXECUTE; retire pulses at cycle 4; instr_count=1; next state FETCH.
- LOAD with mem_ready low 3 cycles in FETCH and 2 in MEM → FETCH held 4 cycles, ir_write/pc_write exactly one cycle; iord=1 in MEM; mem_to_reg=1 in WB; total 10 cycles.
- STORE then BRANCH back to back → mem_we=1 only in the STORE's MEM cycle; BRANCH retires after EXECUTE with pc_write_cond=1, aluop=01; instr_count=2.
- opcode=1111111 in DECODE → ERROR next edge, err_code=01, all controls 0; stays until reset; reset → IDLE, err=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → ERROR after 15 wait cycles, err_code=10. Repeat with mem_ready=1 on the 15th cycle → DECODE, no error.
- run dropped during EXECUTE of an R-type → instruction completes, retire pulses, state goes to IDLE. run re-raised → FETCH next edge. Counter wrap with CNT_W=4: after 16 retires instr_count=0.
